// File: rtl/mapping_pkg.sv
// rtl/mapping_pkg.sv - shared types and constants for the MappingLayer line-buffer scheduler
//
// Contents:
//   sched_state_t         frame sequencing states (IDLE, FILL, RUN, DONE)
//   DEF_LINE_WIDTH        default beats per input line
//   DEF_FRAME_LINES       default lines (and output rows) per frame
//   DEF_NUM_BANKS         default number of line-buffer banks
//   BANK_W/ADDR_W/ROW_W   port widths for bank index, beat address, row index
//   CNT_W                 width of the line occupancy counters
package mapping_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    localparam int DEF_LINE_WIDTH  = 320;
    localparam int DEF_FRAME_LINES = 180;
    localparam int DEF_NUM_BANKS   = 4;

    localparam int BANK_W = 2;
    localparam int ADDR_W = 9;
    localparam int ROW_W  = 8;
    localparam int CNT_W  = 8;

endpackage

// File: rtl/bank_credit_counter.sv
// rtl/bank_credit_counter.sv - line-buffer occupancy tracking (written vs retired lines)
//
// Ports:
//   i_clk          clock
//   i_rstn         synchronous active-low reset
//   i_clr          clear both counters (abort / end of frame); wins over increments
//   i_line_inc     an input line completed this cycle
//   i_free_inc     a line was retired this cycle
//   o_wr_lines     completed input lines, 0..FRAME_LINES
//   o_freed        retired lines
//   o_space_next   frame not fully written and a bank is free, evaluated on the
//                  counter values that will hold after this clock edge
module bank_credit_counter
    import mapping_pkg::*;
#(
    parameter int FRAME_LINES = DEF_FRAME_LINES,
    parameter int NUM_BANKS   = DEF_NUM_BANKS
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clr,
    input  logic             i_line_inc,
    input  logic             i_free_inc,
    output logic [CNT_W-1:0] o_wr_lines,
    output logic [CNT_W-1:0] o_freed,
    output logic             o_space_next
);

    logic [CNT_W-1:0] wr_lines_n;
    logic [CNT_W-1:0] freed_n;
    logic [CNT_W-1:0] occ_n;

    always_comb begin
        wr_lines_n = o_wr_lines;
        freed_n    = o_freed;
        if (i_clr) begin
            wr_lines_n = '0;
            freed_n    = '0;
        end else begin
            if (i_line_inc) wr_lines_n = o_wr_lines + CNT_W'(1);
            if (i_free_inc) freed_n    = o_freed + CNT_W'(1);
        end
    end

    // The reader only retires line y-1 after lines up to y+1 exist, so the
    // difference never underflows.
    assign occ_n        = wr_lines_n - freed_n;
    assign o_space_next = (wr_lines_n < CNT_W'(FRAME_LINES)) && (occ_n < CNT_W'(NUM_BANKS));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_wr_lines <= '0;
            o_freed    <= '0;
        end else begin
            o_wr_lines <= wr_lines_n;
            o_freed    <= freed_n;
        end
    end

endmodule

// File: rtl/line_window_scheduler.sv
// rtl/line_window_scheduler.sv - frame sequencer for the 4-bank line buffer (write gating, 3-line read windows, bank retire)
//
// Optional feature: define SCHED_ERR_STATUS_EN for sticky protocol error flags on o_err.
//
// Ports:
//   i_clk           clock
//   i_rstn          synchronous active-low reset (priority over i_abort)
//   i_start         frame start pulse, honoured only in IDLE
//   i_abort         abandon frame, return to IDLE with counters cleared
//   i_wr_beat       input beat accepted upstream this cycle
//   i_rd_line_done  reader finished the current row window
//   o_wr_allow      registered tready gate for the input stream
//   o_wr_bank       bank receiving the current input line
//   o_wr_addr       beat address within the current input line
//   o_rd_start      one-cycle pulse launching a row window
//   o_rd_base_bank  bank holding line y-1 of the active window
//   o_rd_row        output row y
//   o_pad_top       active window is row 0 (line y-1 is zero)
//   o_pad_bot       active window is the last row (line y+1 is zero)
//   o_busy          frame in progress (FILL or RUN)
//   o_frame_done    one-cycle end-of-frame pulse
//   o_err           sticky errors: [0] beat while gated, [1] stray line-done
module line_window_scheduler
    import mapping_pkg::*;
#(
    parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
    parameter int FRAME_LINES = DEF_FRAME_LINES,
    parameter int NUM_BANKS   = DEF_NUM_BANKS
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_wr_beat,
    input  logic              i_rd_line_done,
    output logic              o_wr_allow,
    output logic [BANK_W-1:0] o_wr_bank,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_rd_start,
    output logic [BANK_W-1:0] o_rd_base_bank,
    output logic [ROW_W-1:0]  o_rd_row,
    output logic              o_pad_top,
    output logic              o_pad_bot,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [1:0]        o_err
);

    sched_state_t     state;
    sched_state_t     state_n;
    logic [CNT_W-1:0] wr_lines;
    logic [CNT_W-1:0] freed;
    logic             space_next;
    logic             rd_active;
    logic             active_st;
    logic             wr_fire;
    logic             line_end;
    logic             retire;
    logic             last_row;
    logic             launch;
    logic             clr;
    logic             free_inc;
    logic [CNT_W:0]   rd_need;

    assign active_st = (state == FILL) || (state == RUN);
    assign wr_fire   = i_wr_beat && o_wr_allow;
    assign line_end  = wr_fire && (o_wr_addr == ADDR_W'(LINE_WIDTH - 1));
    assign retire    = i_rd_line_done && rd_active;
    assign last_row  = (o_rd_row == ROW_W'(FRAME_LINES - 1));
    assign clr       = i_abort || (state == DONE);
    // Row 0 retires no line: line y-1 of row 0 is the zero pad.
    assign free_inc  = retire && (o_rd_row != '0);

    // A window for row y needs lines up to y+1, except the last row which
    // substitutes zeros below the frame.
    always_comb begin
        rd_need = {1'b0, o_rd_row} + (CNT_W + 1)'(2);
        if (rd_need > (CNT_W + 1)'(FRAME_LINES)) begin
            rd_need = (CNT_W + 1)'(FRAME_LINES);
        end
    end

    assign launch = active_st && !rd_active && !i_abort && ({1'b0, wr_lines} >= rd_need);

    bank_credit_counter #(
        .FRAME_LINES (FRAME_LINES),
        .NUM_BANKS   (NUM_BANKS)
    ) u_credit (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_clr        (clr),
        .i_line_inc   (line_end),
        .i_free_inc   (free_inc),
        .o_wr_lines   (wr_lines),
        .o_freed      (freed),
        .o_space_next (space_next)
    );

    always_comb begin
        state_n = state;
        if (i_abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_start) state_n = FILL;
                FILL:    if (launch) state_n = RUN;
                RUN:     if (retire && last_row) state_n = DONE;
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state      <= IDLE;
            o_wr_allow <= 1'b0;
            o_wr_addr  <= '0;
            o_rd_row   <= '0;
            o_rd_start <= 1'b0;
            rd_active  <= 1'b0;
        end else begin
            state <= state_n;
            // Gate computed from post-edge counters so a line completion and a
            // retire landing together are both reflected in the next cycle.
            o_wr_allow <= ((state_n == FILL) || (state_n == RUN)) && space_next;
            if (clr) begin
                o_wr_addr  <= '0;
                o_rd_row   <= '0;
                o_rd_start <= 1'b0;
                rd_active  <= 1'b0;
            end else begin
                o_rd_start <= launch;
                if (wr_fire) begin
                    o_wr_addr <= line_end ? '0 : o_wr_addr + ADDR_W'(1);
                end
                if (launch) begin
                    rd_active <= 1'b1;
                end else if (retire) begin
                    rd_active <= 1'b0;
                end
                if (retire) begin
                    o_rd_row <= o_rd_row + ROW_W'(1);
                end
            end
        end
    end

    assign o_wr_bank      = wr_lines[BANK_W-1:0];
    assign o_rd_base_bank = rd_active ? (o_rd_row[BANK_W-1:0] + BANK_W'(NUM_BANKS - 1)) : '0;
    assign o_pad_top      = rd_active && (o_rd_row == '0);
    assign o_pad_bot      = rd_active && last_row;
    assign o_busy         = active_st;
    assign o_frame_done   = (state == DONE);

`ifdef SCHED_ERR_STATUS_EN
    logic [1:0] err_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            err_q <= 2'b00;
        end else if (i_start) begin
            err_q <= 2'b00;
        end else begin
            if (i_wr_beat && !o_wr_allow) err_q[0] <= 1'b1;
            if (i_rd_line_done && !rd_active) err_q[1] <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 2'b00;
`endif

endmodule
